// File: rtl/rect_stream_out_if.sv
// Pixel input and AXI4-Stream video output of rect_stream_out.
// master = the block itself, slave = the source/sink environment around it.
interface rect_stream_out_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_last;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic       m_tuser;
  logic       m_tlast;

  modport master (
    input  din, din_valid, din_last, m_tready,
    output m_tdata, m_tvalid, m_tuser, m_tlast
  );

  modport slave (
    output din, din_valid, din_last, m_tready,
    input  m_tdata, m_tvalid, m_tuser, m_tlast
  );
endinterface

// File: rtl/rect_stream_out.sv
// Buffers rectified pixels in a small FIFO and replays them as an AXI4-Stream
// video stream with SOF/EOL sideband, checking frame geometry against din_last.
module rect_stream_out #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  rect_stream_out_if.master  s,
  output logic               overflow,
  output logic               frame_err,
  output logic               frame_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } ent_t;

  ent_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;
  logic          done_q, done_d;

  logic empty, full, push, pop, col_end, row_end;
  ent_t head;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign head    = mem_q[rd_ptr_q];
  assign pop     = !empty && s.m_tready;
  assign push    = s.din_valid && (!full || pop);
  assign col_end = (col_q == CW'(IMG_WIDTH - 1));
  assign row_end = (row_q == RW'(IMG_HEIGHT - 1));

  // Sideband is gated by valid so everything reads 0 while the FIFO is empty.
  assign s.m_tvalid = !empty;
  assign s.m_tdata  = empty ? 8'h00 : head.data;
  assign s.m_tuser  = !empty && (col_q == '0) && (row_q == '0);
  assign s.m_tlast  = !empty && col_end;

  assign overflow   = ovf_q;
  assign frame_err  = err_q;
  assign frame_done = done_q;

  // Storage needs no reset: an empty FIFO never exposes its contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{last: s.din_last, data: s.din};
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // A last-flagged pop resynchronises the raster, whatever position it came at.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    ovf_d  = ovf_q | (s.din_valid && full && !pop);
    err_d  = err_q;
    done_d = 1'b0;
    if (pop) begin
      if (head.last) begin
        col_d  = '0;
        row_d  = '0;
        done_d = 1'b1;
        if (!(col_end && row_end)) err_d = 1'b1;
      end else if (col_end) begin
        col_d = '0;
        if (row_end) begin
          row_d = '0;
          err_d = 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q  <= cnt_d;
      col_q  <= col_d;
      row_q  <= row_d;
      ovf_q  <= ovf_d;
      err_q  <= err_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_rect_stream_out.sv
// Directed + randomized bench for rect_stream_out against a queue-based raster model.
module tb_rect_stream_out;
  localparam int W  = 32;
  localparam int H  = 12;
  localparam int D  = 16;
  localparam int FR = W * H;

  logic clk = 1'b0;
  logic rst;
  logic overflow, frame_err, frame_done;

  rect_stream_out_if bus ();

  rect_stream_out #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .s          (bus.master),
    .overflow   (overflow),
    .frame_err  (frame_err),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } px_t;

  px_t        q[$];
  int         k;
  logic       ovf_m, err_m, done_m;
  int         total, bad;
  int         n_pop, n_user, n_last, n_done;
  logic       stall_p;
  logic [7:0] stall_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check outputs, advance the model across posedge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic l, input logic rdy);
    logic pop, push, dn, had;
    px_t  h;
    bus.din = d; bus.din_valid = v; bus.din_last = l; bus.m_tready = rdy;
    #1;
    had = (q.size() > 0);
    chk("tvalid", bus.m_tvalid, had);
    chk("overflow", overflow, ovf_m);
    chk("frame_err", frame_err, err_m);
    chk("frame_done", frame_done, done_m);
    if (frame_done === 1'b1) n_done++;
    if (had) begin
      chk("tdata", bus.m_tdata, q[0].d);
      chk("tuser", bus.m_tuser, k == 0);
      chk("tlast", bus.m_tlast, (k % W) == W - 1);
      if (stall_p) chk("stall_hold", bus.m_tdata, stall_d);
    end
    pop  = had && rdy;
    push = v && (q.size() < D || pop);
    if (v && !push) ovf_m = 1'b1;
    dn = 1'b0;
    if (pop) begin
      h = q.pop_front();
      n_pop++;
      if ((k % W) == W - 1) n_last++;
      if (k == 0) n_user++;
      if (h.l) begin
        if (k != FR - 1) err_m = 1'b1;
        k  = 0;
        dn = 1'b1;
      end else begin
        if (k == FR - 1) err_m = 1'b1;
        k = (k + 1) % FR;
      end
    end
    if (push) q.push_back('{d, l});
    stall_p = had && !rdy;
    stall_d = bus.m_tdata;
    @(posedge clk);
    done_m = dn;
    @(negedge clk);
  endtask

  task automatic drain(input int max);
    int c;
    c = 0;
    while (q.size() > 0 && c < max) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      c++;
    end
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic do_rst();
    bus.din_valid = 1'b0; bus.din_last = 1'b0; bus.m_tready = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_tvalid", bus.m_tvalid, 0);
    chk("rst_tdata", bus.m_tdata, 0);
    chk("rst_tuser", bus.m_tuser, 0);
    chk("rst_tlast", bus.m_tlast, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_frame_done", frame_done, 0);
    q.delete();
    k = 0; ovf_m = 0; err_m = 0; done_m = 0; stall_p = 0;
    n_pop = 0; n_user = 0; n_last = 0; n_done = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int sent;
    logic v;
    rst = 1'b0;
    bus.din = 8'h00; bus.din_valid = 1'b0; bus.din_last = 1'b0; bus.m_tready = 1'b0;
    total = 0; bad = 0; stall_p = 0;
    @(negedge clk);
    do_rst();

    // Full frame, ready always high, last on the final pixel.
    for (int i = 0; i < FR; i++) cyc(1'b1, 8'($urandom), i == FR - 1, 1'b1);
    drain(20);
    chk("s1_pops", n_pop, FR);
    chk("s1_tuser_cnt", n_user, 1);
    chk("s1_tlast_cnt", n_last, H);
    chk("s1_done_cnt", n_done, 1);
    chk("s1_overflow", overflow, 0);
    chk("s1_frame_err", frame_err, 0);

    // Fill while stalled, 17th pixel dropped, then drain in order.
    do_rst();
    for (int i = 0; i < D; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    chk("s2_no_ovf_yet", overflow, 0);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("s2_overflow", overflow, 1);
    n_pop = 0;
    drain(40);
    chk("s2_drained", n_pop, D);

    // Full FIFO with simultaneous push+pop keeps occupancy at D.
    do_rst();
    for (int i = 0; i < D; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b0, 1'b1);
    chk("s3_no_ovf", overflow, 0);
    cyc(1'b1, 8'h66, 1'b0, 1'b0);
    chk("s3_still_full", overflow, 1);
    drain(40);

    // Early last: frame_err sets, frame_done still pulses, next pixel is SOF.
    do_rst();
    for (int i = 0; i < 40; i++) cyc(1'b1, 8'($urandom), i == 39, 1'b1);
    drain(20);
    chk("s4_frame_err", frame_err, 1);
    chk("s4_done_cnt", n_done, 1);
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    chk("s4_next_tuser", bus.m_tuser, 1);
    chk("s4_next_tlast", bus.m_tlast, 0);
    drain(20);

    // Mid-frame reset discards buffered pixels; raster restarts.
    do_rst();
    for (int i = 0; i < 100; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b1);
    chk("s5_pre_valid", bus.m_tvalid, 1);
    do_rst();
    cyc(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("s5_tuser", bus.m_tuser, 1);
    chk("s5_tdata", bus.m_tdata, 8'h3C);
    chk("s5_overflow", overflow, 0);
    chk("s5_frame_err", frame_err, 0);
    drain(20);

    // Random ready and sparse input across two frames.
    do_rst();
    sent = 0;
    for (int c = 0; c < 20000 && sent < 2 * FR; c++) begin
      v = ($urandom % 3) == 0;
      cyc(v, 8'($urandom), v && (sent % FR == FR - 1), 1'($urandom % 2));
      if (v) sent++;
    end
    chk("s6_all_sent", sent, 2 * FR);
    drain(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rect_stream_out.md
RECT_STREAM_OUT -- requirements
Module: rect_stream_out

Interface
REQ-001 Parameter IMG_WIDTH, default 640, pixels per output line.
REQ-002 Parameter IMG_HEIGHT, default 480, lines per output frame.
REQ-003 Parameter FIFO_DEPTH, default 16, power of two >= 4, input buffer depth in pixels.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 din  input  8  rectified pixel from the interpolator.
REQ-007 din_valid  input  1  din qualifier; there is no backpressure towards the source.
REQ-008 din_last  input  1  set with the final pixel of a frame.
REQ-009 m_tdata  output  8  AXI4-Stream video pixel.
REQ-010 m_tvalid  output  1  AXI4-Stream valid.
REQ-011 m_tready  input  1  AXI4-Stream ready.
REQ-012 m_tuser  output  1  start of frame, high on pixel (row 0, col 0) only.
REQ-013 m_tlast  output  1  end of line, high on col IMG_WIDTH-1.
REQ-014 overflow  output  1  sticky; an input pixel was dropped.
REQ-015 frame_err  output  1  sticky; din_last position did not match IMG_WIDTH x IMG_HEIGHT.
REQ-016 frame_done  output  1  one-cycle pulse after the last pixel of a frame is transferred.

Function
REQ-017 The block SHALL buffer {din_last, din} in a FIFO of FIFO_DEPTH 9-bit entries; the occupancy counter width SHALL be clog2(FIFO_DEPTH)+1.
REQ-018 Write condition: din_valid && (!full || pop this cycle).
- Simultaneous push and pop when full SHALL both occur.
- Occupancy SHALL stay unchanged when push and pop occur together.
REQ-019 When din_valid and full and no pop occur together, the pixel SHALL be discarded, overflow SHALL set to 1, and FIFO contents SHALL be unchanged.
REQ-020 Pop condition: m_tvalid && m_tready. m_tvalid SHALL equal FIFO not-empty.
REQ-021 m_tdata, m_tuser and m_tlast SHALL be driven from the FIFO head. They SHALL hold stable while m_tvalid=1 and m_tready=0.
REQ-022 Latency: a pixel written into an empty FIFO at edge N SHALL present m_tvalid=1 after edge N. There is no combinational din-to-m_tdata bypass.
REQ-023 Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) SHALL advance only on pop.
- col SHALL wrap to 0 after IMG_WIDTH-1, and row SHALL increment at that wrap.
- row SHALL wrap to 0 after IMG_HEIGHT-1.
REQ-024 m_tuser = (col==0 && row==0). m_tlast = (col==IMG_WIDTH-1).
REQ-025 On pop of an entry with last bit = 1:
- col and row SHALL be forced to 0 (resynchronisation).
- frame_done SHALL pulse high for exactly one cycle on the following cycle.
REQ-026 If that entry's position is not (IMG_WIDTH-1, IMG_HEIGHT-1), frame_err SHALL set to 1 and REQ-025 SHALL still apply.
REQ-027 If counters wrap to (0,0) without a last-flagged entry, frame_err SHALL set to 1 and frame_done SHALL NOT pulse.
REQ-028 overflow and frame_err SHALL clear only by reset.
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-030 While rst=0, the block SHALL asynchronously clear:
- FIFO pointers and occupancy, so the FIFO is empty.
- col and row.
- m_tvalid, m_tuser, m_tlast, m_tdata, overflow, frame_err and frame_done, all to 0.
REQ-031 Reset asserted mid-frame SHALL discard all buffered pixels. After release, the first popped pixel SHALL carry m_tuser=1.
REQ-032 After rst deasserts, din SHALL be accepted from the first rising edge.

Verification
REQ-033 Scenario 1: m_tready=1 constantly; 640x480 frame with din_valid every cycle and din_last on pixel 307199 -> 307200 transfers, and m_tuser=1 only on the first.
REQ-034 Scenario 1, line and frame checks:
- m_tlast=1 on every 640th pixel.
- frame_done pulses once, one cycle after the last transfer.
- overflow=0 and frame_err=0.
REQ-035 Scenario 2: m_tready=0 while 16 pixels 0x00..0x0F are pushed (FIFO_DEPTH=16), then a 17th pixel 0xAA -> 0xAA is dropped and overflow=1.
REQ-036 Scenario 2, drain: release m_tready -> 0x00..0x0F drained in order.
REQ-037 Scenario 3: FIFO full, m_tready=1 and din_valid=1 in the same cycle -> both push and pop occur, occupancy stays 16 and overflow stays 0.
REQ-038 Scenario 4: din_last on pixel 1000 -> frame_err=1, frame_done pulses, and the next pixel has m_tuser=1 with col=0.
REQ-039 Scenario 5: rst=0 for 1 cycle after 5000 pixels of a frame -> m_tvalid=0 immediately. The next pushed pixel appears with m_tuser=1 and overflow/frame_err=0.
REQ-040 Scenario 6: random m_tready at 50% duty -> m_tdata stays stable while stalled, and the output sequence equals the input sequence.
